// File: rtl/mcu_pkg.sv
// Shared definitions for the MCU SPI slave: target codes, frame states and
// the synchronizer pin ordering.
package mcu_pkg;

   localparam logic [7:0] MCU_TGT_SYS = 8'h00;
   localparam logic [7:0] MCU_TGT_HID = 8'h01;
   localparam logic [7:0] MCU_TGT_OSD = 8'h02;
   localparam logic [7:0] MCU_TGT_SDC = 8'h03;

   localparam int SPI_NPINS = 3;
   localparam int SPI_SS    = 0;
   localparam int SPI_CLK   = 1;
   localparam int SPI_DIN   = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TARGET  = 2'd1,
      PAYLOAD = 2'd2
   } mcu_state_e;

   // One-hot strobe vector {sdc, osd, hid, sys}; zero for unknown codes.
   function automatic logic [3:0] tgt_strobe(input logic [7:0] tgt);
      logic [3:0] stb;
      case (tgt)
         MCU_TGT_SYS: stb = 4'b0001;
         MCU_TGT_HID: stb = 4'b0010;
         MCU_TGT_OSD: stb = 4'b0100;
         MCU_TGT_SDC: stb = 4'b1000;
         default:     stb = 4'b0000;
      endcase
      return stb;
   endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchronizer for the SPI pins with registered SCLK rise/fall
// and SS fall detection, one stage behind the synchronizer.
module spi_sync
   import mcu_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [SPI_NPINS-1:0] i_pins,
   output logic                 o_ss_level,
   output logic                 o_din_level,
   output logic                 o_sclk_rise,
   output logic                 o_sclk_fall,
   output logic                 o_ss_fall
);

   logic [SPI_NPINS-1:0] r_sync [SYNC_STAGES];
   logic [SPI_NPINS-1:0] r_level;
   logic                 r_sclk_rise;
   logic                 r_sclk_fall;
   logic                 r_ss_fall;
   logic [SPI_NPINS-1:0] w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // Synchronizer chain and edge detectors; SS resets low so a frame that
   // is already in progress at reset release never produces a falling edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
         r_level     <= '0;
         r_sclk_rise <= 1'b0;
         r_sclk_fall <= 1'b0;
         r_ss_fall   <= 1'b0;
      end else begin
         r_sync[0] <= i_pins;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
         r_level     <= w_sync;
         r_sclk_rise <=  w_sync[SPI_CLK] & ~r_level[SPI_CLK];
         r_sclk_fall <= ~w_sync[SPI_CLK] &  r_level[SPI_CLK];
         r_ss_fall   <= ~w_sync[SPI_SS]  &  r_level[SPI_SS];
      end
   end

   assign o_ss_level  = r_level[SPI_SS];
   assign o_din_level = r_level[SPI_DIN];
   assign o_sclk_rise = r_sclk_rise;
   assign o_sclk_fall = r_sclk_fall;
   assign o_ss_fall   = r_ss_fall;

endmodule

// File: rtl/mcu_spi.sv
// SPI slave front end for the companion MCU: first byte of a frame selects a
// target, later bytes are strobed to it, and its reply is shifted out on MISO.
module mcu_spi
   import mcu_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_io_ss,
   input  logic       spi_io_clk,
   input  logic       spi_io_din,
   output logic       spi_io_dout,
   output logic       mcu_sys_strobe,
   output logic       mcu_hid_strobe,
   output logic       mcu_osd_strobe,
   output logic       mcu_sdc_strobe,
   output logic       mcu_start,
   output logic [7:0] mcu_dout,
   input  logic [7:0] mcu_sys_din,
   input  logic [7:0] mcu_hid_din,
   input  logic [7:0] mcu_osd_din,
   input  logic [7:0] mcu_sdc_din
);

   logic [SPI_NPINS-1:0] w_pins;
   logic       w_ss_high, w_mosi, w_sclk_rise, w_sclk_fall, w_ss_fall;
   logic       w_byte_done;
   logic [7:0] w_rx_byte, w_sel_din;
   logic [3:0] w_tgt_stb;

   mcu_state_e r_state, w_state_nxt;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_rx, w_rx_nxt;
   logic [7:0] r_target, w_target_nxt;
   logic       r_first, w_first_nxt;
   logic [7:0] r_tx, w_tx_nxt;
   logic       r_miso, w_miso_nxt;
   logic [7:0] r_dout, w_dout_nxt;
   logic       r_start, w_start_nxt;
   logic [3:0] r_strobe, w_strobe_nxt;

   assign w_pins[SPI_SS]  = spi_io_ss;
   assign w_pins[SPI_CLK] = spi_io_clk;
   assign w_pins[SPI_DIN] = spi_io_din;

   spi_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_pins      (w_pins),
      .o_ss_level  (w_ss_high),
      .o_din_level (w_mosi),
      .o_sclk_rise (w_sclk_rise),
      .o_sclk_fall (w_sclk_fall),
      .o_ss_fall   (w_ss_fall)
   );

   assign w_rx_byte   = {r_rx[6:0], w_mosi};
   assign w_tgt_stb   = tgt_strobe(r_target);
   assign w_byte_done = (r_state != IDLE) && w_sclk_rise && (r_bit_cnt == 3'd7);

   // Reply byte of the currently selected target.
   always_comb begin
      case (r_target)
         MCU_TGT_SYS: w_sel_din = mcu_sys_din;
         MCU_TGT_HID: w_sel_din = mcu_hid_din;
         MCU_TGT_OSD: w_sel_din = mcu_osd_din;
         MCU_TGT_SDC: w_sel_din = mcu_sdc_din;
         default:     w_sel_din = 8'h00;
      endcase
   end

   // Frame FSM, receive/transmit shifters and output strobes.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_rx_nxt      = r_rx;
      w_target_nxt  = r_target;
      w_first_nxt   = r_first;
      w_tx_nxt      = r_tx;
      w_miso_nxt    = r_miso;
      w_dout_nxt    = r_dout;
      w_start_nxt   = 1'b0;
      w_strobe_nxt  = 4'b0000;

      // A completed payload byte is delivered even if SS rises in the same cycle.
      if (w_byte_done && (r_state == PAYLOAD)) begin
         w_strobe_nxt = w_tgt_stb;
         w_start_nxt  = r_first & (|w_tgt_stb);
         w_first_nxt  = 1'b0;
         if (|w_tgt_stb) begin
            w_dout_nxt = w_rx_byte;
         end else begin
            w_dout_nxt = r_dout;
         end
      end else begin
         w_strobe_nxt = 4'b0000;
      end

      if (r_state == IDLE) begin
         w_bit_cnt_nxt = 3'd0;
         if (w_ss_fall) begin
            w_state_nxt = TARGET;
            w_rx_nxt    = 8'h00;
            w_tx_nxt    = 8'h00;
            w_miso_nxt  = 1'b0;
            w_first_nxt = 1'b0;
         end else begin
            w_state_nxt = IDLE;
         end
      end else if (w_ss_high) begin
         w_state_nxt   = IDLE;
         w_bit_cnt_nxt = 3'd0;
      end else if (w_sclk_rise) begin
         w_rx_nxt      = w_rx_byte;
         w_bit_cnt_nxt = r_bit_cnt + 3'd1;
         if (w_byte_done && (r_state == TARGET)) begin
            w_state_nxt  = PAYLOAD;
            w_target_nxt = w_rx_byte;
            w_first_nxt  = 1'b1;
         end else begin
            w_state_nxt = r_state;
         end
      end else if (w_sclk_fall) begin
         if ((r_state == PAYLOAD) && (r_bit_cnt == 3'd0)) begin
            w_tx_nxt   = w_sel_din;
            w_miso_nxt = w_sel_din[7];
         end else begin
            w_tx_nxt   = {r_tx[6:0], 1'b0};
            w_miso_nxt = r_tx[6];
         end
      end else begin
         w_tx_nxt = r_tx;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_rx      <= 8'h00;
         r_target  <= MCU_TGT_SYS;
         r_first   <= 1'b0;
         r_tx      <= 8'h00;
         r_miso    <= 1'b0;
         r_dout    <= 8'h00;
         r_start   <= 1'b0;
         r_strobe  <= 4'b0000;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_rx      <= w_rx_nxt;
         r_target  <= w_target_nxt;
         r_first   <= w_first_nxt;
         r_tx      <= w_tx_nxt;
         r_miso    <= w_miso_nxt;
         r_dout    <= w_dout_nxt;
         r_start   <= w_start_nxt;
         r_strobe  <= w_strobe_nxt;
      end
   end

   assign spi_io_dout    = r_miso;
   assign mcu_sys_strobe = r_strobe[0];
   assign mcu_hid_strobe = r_strobe[1];
   assign mcu_osd_strobe = r_strobe[2];
   assign mcu_sdc_strobe = r_strobe[3];
   assign mcu_start      = r_start;
   assign mcu_dout       = r_dout;

endmodule

// File: tb/tb_mcu_spi.sv
// Directed and random frames against mcu_spi; a scoreboard queue holds the
// strobes expected from each received byte, checked as the DUT raises them.
module tb_mcu_spi;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = SYNC_STAGES + 3;

   typedef struct packed {
      logic [3:0]  stb;
      logic [7:0]  data;
      logic        start;
      logic [31:0] cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       spi_io_ss, spi_io_clk, spi_io_din, spi_io_dout;
   logic       mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
   logic       mcu_start;
   logic [7:0] mcu_dout;
   logic [7:0] mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din;

   logic [7:0] sys_din_stim;
   logic [7:0] sys_din_mon = 8'h00;
   logic       sys_use_mon;

   exp_t       q_exp[$];
   logic [7:0] q_sys_reply[$];
   exp_t       mon_e;
   logic [3:0] mon_stb;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [31:0] cyc = 32'd0;

   assign mcu_sys_din = sys_use_mon ? sys_din_mon : sys_din_stim;

   mcu_spi #(.SYNC_STAGES(SYNC_STAGES)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .spi_io_ss      (spi_io_ss),
      .spi_io_clk     (spi_io_clk),
      .spi_io_din     (spi_io_din),
      .spi_io_dout    (spi_io_dout),
      .mcu_sys_strobe (mcu_sys_strobe),
      .mcu_hid_strobe (mcu_hid_strobe),
      .mcu_osd_strobe (mcu_osd_strobe),
      .mcu_sdc_strobe (mcu_sdc_strobe),
      .mcu_start      (mcu_start),
      .mcu_dout       (mcu_dout),
      .mcu_sys_din    (mcu_sys_din),
      .mcu_hid_din    (mcu_hid_din),
      .mcu_osd_din    (mcu_osd_din),
      .mcu_sdc_din    (mcu_sdc_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every strobe must match the oldest expected byte.
   always @(negedge clk) begin
      if (reset_n) begin
         mon_stb = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe};
         if (mon_stb != 4'b0000) begin
            chk("strobe_onehot", 32'($countones(mon_stb)), 32'd1);
            if (q_exp.size() == 0) begin
               chk("unexpected_strobe", 32'(mon_stb), 32'd0);
            end else begin
               mon_e = q_exp.pop_front();
               chk("strobe_target", 32'(mon_stb), 32'(mon_e.stb));
               chk("mcu_dout", 32'(mcu_dout), 32'(mon_e.data));
               chk("mcu_start", 32'(mcu_start), 32'(mon_e.start));
               chk("latency", cyc - mon_e.cyc, 32'(SYNC_STAGES + 2));
               if (mon_stb[0] && (q_sys_reply.size() > 0)) sys_din_mon = q_sys_reply.pop_front();
            end
         end else if (mcu_start) begin
            chk("start_without_strobe", 32'(mcu_start), 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, input logic push,
                       input logic [3:0] stb, input logic start, input logic ss_last,
                       output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_io_din = tx[7-i];
         tick(HALF);
         rx[7-i] = spi_io_dout;
         spi_io_clk = 1'b1;
         if (i == 7) begin
            if (push) q_exp.push_back('{stb: stb, data: tx, start: start, cyc: cyc});
            if (ss_last) spi_io_ss = 1'b1;
         end
         tick(HALF);
         spi_io_clk = 1'b0;
      end
   endtask

   task automatic pb(input string tag, input logic [7:0] tx, input logic push,
                     input logic [3:0] stb, input logic start, input logic [7:0] exp_miso);
      logic [7:0] rx;
      xfer(tx, 8, push, stb, start, 1'b0, rx);
      chk(tag, 32'(rx), 32'(exp_miso));
   endtask

   task automatic ss_high();
      tick(HALF);
      spi_io_ss = 1'b1;
      tick(8);
   endtask

   task automatic check_idle_outputs();
      chk("rst_strobes", 32'({mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}), 32'd0);
      chk("rst_start", 32'(mcu_start), 32'd0);
      chk("rst_dout", 32'(mcu_dout), 32'd0);
      chk("rst_miso", 32'(spi_io_dout), 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] tdin [4];
      int         tgt, len;
      logic [7:0] d;

      reset_n = 1'b0;
      spi_io_ss = 1'b1; spi_io_clk = 1'b0; spi_io_din = 1'b0;
      sys_din_stim = 8'h00; sys_use_mon = 1'b1;
      mcu_hid_din = 8'hA1; mcu_osd_din = 8'hB2; mcu_sdc_din = 8'hC4;
      tick(4);
      reset_n = 1'b1;
      tick(6);
      check_idle_outputs();

      // Readback: sys replies change after the first and second strobes.
      q_sys_reply.push_back(8'h5C);
      q_sys_reply.push_back(8'h42);
      spi_io_ss = 1'b0;
      pb("rb_miso0", 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("rb_miso1", 8'h10, 1'b1, 4'b0001, 1'b1, 8'h00);
      pb("rb_miso2", 8'h20, 1'b1, 4'b0001, 1'b0, 8'h5C);
      pb("rb_miso3", 8'h30, 1'b1, 4'b0001, 1'b0, 8'h42);
      ss_high();
      sys_use_mon = 1'b0;
      sys_din_stim = 8'h96;

      // Basic sys frame.
      spi_io_ss = 1'b0;
      pb("sys_miso0", 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("sys_miso1", 8'h03, 1'b1, 4'b0001, 1'b1, 8'h96);
      pb("sys_miso2", 8'hAA, 1'b1, 4'b0001, 1'b0, 8'h96);
      pb("sys_miso3", 8'h55, 1'b1, 4'b0001, 1'b0, 8'h96);
      ss_high();

      // Unknown target: no strobes, MISO stays zero.
      spi_io_ss = 1'b0;
      pb("unk_miso0", 8'h07, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("unk_miso1", 8'h11, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("unk_miso2", 8'h22, 1'b0, 4'b0000, 1'b0, 8'h00);
      ss_high();
      chk("unk_dout_held", 32'(mcu_dout), 32'h55);

      // SS rise after 5 bits of a third byte.
      spi_io_ss = 1'b0;
      pb("hid_miso0", 8'h01, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("hid_miso1", 8'h80, 1'b1, 4'b0010, 1'b1, 8'hA1);
      xfer(8'hFF, 5, 1'b0, 4'b0000, 1'b0, 1'b0, rx);
      ss_high();
      spi_io_ss = 1'b0;
      pb("osd_miso0", 8'h02, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("osd_miso1", 8'h33, 1'b1, 4'b0100, 1'b1, 8'hB2);
      ss_high();

      // Byte completion and SS rise land in the same clk cycle.
      spi_io_ss = 1'b0;
      pb("sdc_miso0", 8'h03, 1'b0, 4'b0000, 1'b0, 8'h00);
      xfer(8'h5A, 8, 1'b1, 4'b1000, 1'b1, 1'b1, rx);
      chk("sdc_miso1", 32'(rx), 32'hC4);
      ss_high();
      chk("after_same_cycle_empty", 32'(q_exp.size()), 32'd0);

      // Reset mid-frame with SS held low; no strobe until a fresh SS fall.
      spi_io_ss = 1'b0;
      pb("rm_miso0", 8'h02, 1'b0, 4'b0000, 1'b0, 8'h00);
      xfer(8'h44, 3, 1'b0, 4'b0000, 1'b0, 1'b0, rx);
      reset_n = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      check_idle_outputs();
      pb("rm_ign0", 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("rm_ign1", 8'h12, 1'b0, 4'b0000, 1'b0, 8'h00);
      ss_high();
      chk("rm_dout_still_zero", 32'(mcu_dout), 32'd0);
      spi_io_ss = 1'b0;
      pb("rm_miso_t", 8'h03, 1'b0, 4'b0000, 1'b0, 8'h00);
      pb("rm_miso_p", 8'h9E, 1'b1, 4'b1000, 1'b1, 8'hC4);
      ss_high();

      // Random frames at clk/10 to random valid targets.
      tdin[0] = sys_din_stim; tdin[1] = mcu_hid_din; tdin[2] = mcu_osd_din; tdin[3] = mcu_sdc_din;
      for (int f = 0; f < 4; f++) begin
         tgt = int'($urandom_range(0, 3));
         len = int'($urandom_range(1, 20));
         spi_io_ss = 1'b0;
         pb("rnd_miso_t", 8'(tgt), 1'b0, 4'b0000, 1'b0, 8'h00);
         for (int k = 0; k < len; k++) begin
            d = 8'($urandom_range(0, 255));
            pb("rnd_miso_p", d, 1'b1, 4'(1 << tgt), (k == 0), tdin[tgt]);
         end
         ss_high();
      end

      tick(20);
      chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mcu_spi.md
# mcu_spi

SPI slave front end between the Tang Nano 20k's companion MCU and the system-side consumers (sysctrl, HID, OSD, SD card). It runs on the system clock and oversamples the MCU's SPI pins. It turns the serial stream into per-target byte strobes with a start-of-message flag, and shifts the selected target's reply byte back on MISO. The first byte of every SS-low frame selects the target. All later bytes in the frame are payload for that target.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_io_ss`, `spi_io_clk` and `spi_io_din`; minimum 2.
- `clk` in 1: system clock; all logic is in this domain.
- `reset_n` in 1: reset, asynchronous and active-low.
- `spi_io_ss` in 1: SPI chip select, active low.
- `spi_io_clk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
- `spi_io_din` in 1: MOSI.
- `spi_io_dout` out 1: MISO, registered.
- `mcu_sys_strobe`, `mcu_hid_strobe`, `mcu_osd_strobe`, `mcu_sdc_strobe` out 1 each: one-cycle pulse per received payload byte for that target.
- `mcu_start` out 1: qualifies a strobe; high only on the first payload byte of a frame.
- `mcu_dout` out 8: received payload byte; valid while any strobe is high, held otherwise.
- `mcu_sys_din`, `mcu_hid_din`, `mcu_osd_din`, `mcu_sdc_din` in 8 each: reply bytes from each target.

## Operation
- **Input conditioning.** All three SPI inputs go through `SYNC_STAGES` flops. Rising and falling SCLK edges are detected on the synchronized signal, one stage after the synchronizer.
- **States.**
  - IDLE: SS high.
  - TARGET: receiving byte 0 of the frame.
  - PAYLOAD: receiving bytes 1..n.
- **Transitions.**
  - IDLE→TARGET on synchronized SS falling.
  - TARGET→PAYLOAD when 8 bits have been received; the target register latches the byte.
  - Any state→IDLE on synchronized SS high.
- **Receive.** On each synchronized SCLK rise with SS low, shift in MOSI (MSB first) and increment a 3-bit bit counter. The counter wraps 7→0 when a byte completes.
- **Target codes** (from the package): 0x00 sys, 0x01 hid, 0x02 osd, 0x03 sdc. Any other code means payload bytes are consumed with no strobe, and MISO returns 0x00.
- **Payload byte complete.**
  - `mcu_dout` takes the byte and the selected target's strobe pulses.
  - `mcu_start` = 1 if this is the first payload byte since the TARGET byte, otherwise 0.
- **Transmit.**
  - On a synchronized SCLK fall with bit counter = 0 in PAYLOAD state, load the tx shift register from the selected target's `*_din`. Drive bit 7 immediately.
  - On other SCLK falls, shift left and drive the next bit.
  - During TARGET state, and before the first load, MISO = 0.
  - This arrangement means byte n+1 on MISO carries the target's reply to byte n.
- **SS deassert mid-byte.** The partial byte is discarded with no strobe, the bit counter clears, and the state returns to IDLE.
- **Byte completion and SS rise in the same `clk` cycle.** The completed byte is delivered (strobe fires), then the block enters IDLE.
- **Frame with only the TARGET byte.** No strobes are generated.
- **Reset values.** All strobes 0; `mcu_start` 0; `mcu_dout` 0x00; `spi_io_dout` 0; state IDLE; bit counter 0; target 0x00; tx/rx shift registers 0. Reset mid-frame abandons the frame. After reset the block waits for a fresh SS falling edge, even if SS is already low.

## Timing
- Receive latency: a strobe is asserted `SYNC_STAGES`+2 `clk` cycles after the pin-level 8th SCLK rise of a byte.
- Strobes are one cycle wide, and at most one strobe is high per cycle.
- MISO changes `SYNC_STAGES`+2 `clk` cycles after the pin-level SCLK fall.
- SCLK high and low phases must each be ≥ `SYNC_STAGES`+3 `clk` cycles. With the default this gives SCLK ≤ clk/10.
- SS must stay high for ≥ `SYNC_STAGES`+2 `clk` cycles between frames.
- Targets must present their reply on `*_din` within 1 `clk` of their strobe. sysctrl's registered `data_out` meets this.

## Structure
- Package `mcu_pkg` holds the target code constants (`MCU_TGT_SYS`/`HID`/`OSD`/`SDC`) and the state enum (IDLE, TARGET, PAYLOAD).
- Sub-module `spi_sync` is a parameterized multi-bit synchronizer plus rise/fall edge detector for SCLK and SS. It is instantiated once.

## Test plan
- **Basic sys frame.** Frame of 0x00, 0x03, 0xAA, 0x55 → `mcu_sys_strobe` pulses 3 times. `mcu_dout` = 0x03 with start=1, then 0xAA and 0x55 with start=0. No other strobes fire.
- **Readback.** Sys frame with `mcu_sys_din` updated to 0x5C after the first strobe and 0x42 after the second → MISO bytes are 0x00, 0x00, 0x5C, 0x42.
- **Unknown target.** Frame 0x07, 0x11, 0x22 → no strobes; MISO reads 0x00 throughout.
- **SS rise mid-byte.** Frame 0x01, 0x80, then SS rises after 5 bits of a third byte → exactly one hid strobe (0x80). The next frame 0x02, 0x33 gives an osd strobe with start=1 and data 0x33.
- **Reset mid-frame.** Assert `reset_n` low mid-frame with SS held low, then release → all outputs at reset values. No strobe until SS has gone high then low again.
- **Timing check.** Run SCLK at exactly clk/10 with random payloads of 1–20 bytes to random valid targets → every byte is delivered in order, and strobe latency equals `SYNC_STAGES`+2 cycles.
